// File: rtl/alu_serial_host_if.sv
// Bundle of request, ALU-drive and response signals for alu_serial_host.
// slave  = the host controller itself.
// master = the requester/consumer side, which also plays the bit-serial ALU.
interface alu_serial_host_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [2:0] req_op;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_c;
  logic       alu_carry;
  logic       alu_sign;
  logic       alu_zero;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_c;
  logic [2:0] rsp_flags;
  logic       rsp_err;
  logic       chk_mismatch;

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  alu_c, alu_carry, alu_sign, alu_zero,
    input  rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_c, rsp_flags, rsp_err, chk_mismatch
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
    output alu_c, alu_carry, alu_sign, alu_zero,
    output rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_c, rsp_flags, rsp_err, chk_mismatch
  );
endinterface

// File: rtl/alu_serial_host.sv
// Host controller for the bit-serial 4-bit ALU: takes one request, drives the
// ALU for exactly one full serial pass, captures result/flags, checks them
// against a reference model and returns them on a valid/ready response.
module alu_serial_host #(
  parameter int HOLD_CYCLES   = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  alu_serial_host_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic [3:0]       r_alu_a;
  logic [3:0]       r_alu_b;
  logic [2:0]       r_alu_op;
  logic [6:0]       r_exp;          // {c, carry, sign, zero} from the model
  logic             r_rsp_valid;
  logic [3:0]       r_rsp_c;
  logic [2:0]       r_rsp_flags;
  logic             r_rsp_err;
  logic             r_chk_mismatch;

  logic [4:0] w_sum;
  logic [4:0] w_diff;
  logic [3:0] w_c;
  logic       w_carry;
  logic       w_legal;
  logic [6:0] w_exp;
  logic [6:0] w_capt;
  logic       w_mis;

  // Reference model of the ALU, evaluated on the incoming request.
  always_comb begin
    w_sum   = {1'b0, bus.req_a} + {1'b0, bus.req_b};
    w_diff  = {1'b0, bus.req_a} - {1'b0, bus.req_b};
    w_c     = 4'd0;
    w_carry = 1'b0;
    w_legal = 1'b1;
    case (bus.req_op)
      OP_ADD: begin w_c = w_sum[3:0];  w_carry = w_sum[4];  end
      OP_SUB: begin w_c = w_diff[3:0]; w_carry = w_diff[4]; end  // borrow
      OP_AND: w_c = bus.req_a & bus.req_b;
      OP_XOR: w_c = bus.req_a ^ bus.req_b;
      default: w_legal = 1'b0;
    endcase
    w_exp = {w_c, w_carry, w_c[3], (w_c == 4'd0)};
  end

  assign w_capt = {bus.alu_c, bus.alu_carry, bus.alu_sign, bus.alu_zero};
  assign w_mis  = (w_capt != r_exp);

  // Control FSM plus all registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_req_ready    <= 1'b1;
      r_alu_a        <= 4'd0;
      r_alu_b        <= 4'd0;
      r_alu_op       <= 3'd0;
      r_exp          <= 7'd0;
      r_rsp_valid    <= 1'b0;
      r_rsp_c        <= 4'd0;
      r_rsp_flags    <= 3'd0;
      r_rsp_err      <= 1'b0;
      r_chk_mismatch <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_exp       <= w_exp;
            if (w_legal) begin
              r_alu_a  <= bus.req_a;
              r_alu_b  <= bus.req_b;
              r_alu_op <= bus.req_op;
              r_cnt    <= '0;
              r_state  <= S_ISSUE;
            end else begin
              // Error response is prepared now; rsp_valid follows one clock
              // later from RESP. The ALU is left untouched.
              r_rsp_c     <= 4'd0;
              r_rsp_flags <= 3'd0;
              r_rsp_err   <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          // Exactly HOLD_CYCLES clocks of op so the ALU's phase counter wraps.
          if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            r_alu_op <= 3'd0;
            r_cnt    <= '0;
            r_state  <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          r_rsp_c     <= bus.alu_c;
          r_rsp_flags <= {bus.alu_carry, bus.alu_sign, bus.alu_zero};
          r_rsp_err   <= w_mis;
          if (w_mis) r_chk_mismatch <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // Entered with rsp_valid low only on the illegal-op path.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_alu_op    <= 3'd0;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_op       = r_alu_op;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_c        = r_rsp_c;
  assign bus.rsp_flags    = r_rsp_flags;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.chk_mismatch = r_chk_mismatch;

endmodule

// File: tb/tb_alu_serial_host.sv
// Bench for alu_serial_host: acts as requester, response consumer and a
// behavioural ALU stub with a fault-injection mask on its result.
module tb_alu_serial_host;
  localparam int HOLD   = 5;
  localparam int SETTLE = 1;
  localparam int LAT    = HOLD + SETTLE + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_serial_host_if bus();

  alu_serial_host #(.HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Arithmetic reference: returns {legal, c[3:0], carry, sign, zero}.
  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    int ia = int'(a);
    int ib = int'(b);
    int r;
    logic [3:0] c;
    logic cy;
    case (op)
      3'b010: begin r = ia + ib; c = 4'(r % 16); cy = (r > 15); end
      3'b100: begin r = ia - ib; c = 4'((r + 16) % 16); cy = (ia < ib); end
      3'b011: begin c = a & b; cy = 1'b0; end
      3'b001: begin c = a ^ b; cy = 1'b0; end
      default: return 8'd0;
    endcase
    return {1'b1, c, cy, c[3], (c == 4'd0)};
  endfunction

  // ALU stub: remembers the op it was driven with and presents the result
  // of that op on the held operands, optionally corrupted by fault.
  logic [2:0] stub_op = 3'd0;
  logic [3:0] fault   = 4'd0;
  logic [7:0] stub_m;
  always @(posedge clk) if (bus.alu_op != 3'b000) stub_op <= bus.alu_op;
  always_comb stub_m = model(bus.alu_a, bus.alu_b, stub_op);
  assign bus.alu_c     = stub_m[6:3] ^ fault;
  assign bus.alu_carry = stub_m[2];
  assign bus.alu_sign  = stub_m[1];
  assign bus.alu_zero  = stub_m[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request; returns at #1 after the accepting edge E0.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [7:0] m;
    m = model(a, b, op);
    for (int n = 0; n < 50 && !bus.req_ready; n++) begin @(posedge clk); #1; end
    chk("req_ready before request", bus.req_ready, 1);
    bus.req_a = a; bus.req_b = b; bus.req_op = op; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("alu_op after accept", bus.alu_op, m[7] ? op : 3'd0);
    chk("req_ready after accept", bus.req_ready, 0);
  endtask

  // Follow the operation from E0 to the response, hold it off for 'stall'
  // clocks, then complete the handshake.
  task automatic get_rsp(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic [3:0] ec, input logic [2:0] ef, input logic ee,
                         input int stall);
    logic [7:0] m;
    int lat, n;
    bit got;
    m   = model(a, b, op);
    lat = m[7] ? LAT : 1;
    got = 0;
    for (n = 1; n <= LAT + 20; n++) begin
      @(posedge clk); #1;
      if (m[7] && n < LAT)
        chk("alu drive", {bus.alu_op, bus.alu_a, bus.alu_b},
            {((n < HOLD) ? op : 3'd0), a, b});
      else
        chk("alu idle", bus.alu_op, 0);
      chk("req_ready busy", bus.req_ready, 0);
      if (bus.rsp_valid) begin got = 1; break; end
    end
    chk("rsp latency", n, lat);
    if (got) begin
      chk("rsp data", {bus.rsp_c, bus.rsp_flags, bus.rsp_err}, {ec, ef, ee});
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk("rsp stalled", {bus.rsp_valid, bus.rsp_c, bus.rsp_flags, bus.rsp_err,
                            bus.req_ready, bus.alu_op}, {1'b1, ec, ef, ee, 1'b0, 3'd0});
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("after handshake", {bus.rsp_valid, bus.req_ready}, 2'b01);
    end
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic [2:0] op;
    logic [3:0] c;
    logic [2:0] flags;
    logic       err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] m;
    logic [3:0] ec;
    logic [2:0] ef;
    logic       ee;
    logic       exp_mis;
    logic [3:0] ra, rb;
    logic [2:0] rop;

    vecs[0]  = '{4'b0111, 4'b1001, 3'b010, 4'b0000, 3'b101, 1'b0}; // ADD wraps to 0
    vecs[1]  = '{4'b0011, 4'b0101, 3'b100, 4'b1110, 3'b110, 1'b0}; // SUB borrow
    vecs[2]  = '{4'b1100, 4'b1010, 3'b011, 4'b1000, 3'b010, 1'b0}; // AND
    vecs[3]  = '{4'b1111, 4'b0001, 3'b110, 4'b0000, 3'b000, 1'b1}; // illegal
    vecs[4]  = '{4'b1010, 4'b0101, 3'b001, 4'b1111, 3'b010, 1'b0}; // XOR
    vecs[5]  = '{4'b1111, 4'b0001, 3'b010, 4'b0000, 3'b101, 1'b0}; // ADD carry
    vecs[6]  = '{4'b0101, 4'b0101, 3'b100, 4'b0000, 3'b001, 1'b0}; // SUB equal
    vecs[7]  = '{4'b0000, 4'b0001, 3'b100, 4'b1111, 3'b110, 1'b0}; // SUB 0-1
    vecs[8]  = '{4'b0011, 4'b0100, 3'b010, 4'b0111, 3'b000, 1'b0}; // ADD plain
    vecs[9]  = '{4'b0001, 4'b0010, 3'b000, 4'b0000, 3'b000, 1'b1}; // idle code
    vecs[10] = '{4'b0110, 4'b0011, 3'b111, 4'b0000, 3'b000, 1'b1}; // illegal

    bus.req_valid = 1'b0; bus.req_a = 4'd0; bus.req_b = 4'd0; bus.req_op = 3'd0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset handshake", {bus.req_ready, bus.rsp_valid}, 2'b10);
    chk("reset alu", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
    chk("reset rsp", {bus.rsp_c, bus.rsp_flags, bus.rsp_err, bus.chk_mismatch}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors; back-to-back with varying response stalls
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op);
      get_rsp(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].c, vecs[i].flags, vecs[i].err, i % 3);
    end
    chk("no mismatch after clean ops", bus.chk_mismatch, 0);

    // Injected ALU fault: XOR 0101^0101 returns 0001 instead of 0000
    fault = 4'b0001;
    send(4'b0101, 4'b0101, 3'b001);
    get_rsp(4'b0101, 4'b0101, 3'b001, 4'b0001, 3'b001, 1'b1, 0);
    fault = 4'b0000;
    chk("mismatch sets sticky", bus.chk_mismatch, 1);
    send(vecs[0].a, vecs[0].b, vecs[0].op);
    get_rsp(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].c, vecs[0].flags, vecs[0].err, 0);
    chk("mismatch stays sticky", bus.chk_mismatch, 1);

    // Backpressure with a pending request behind it
    send(4'b0010, 4'b0011, 3'b010);
    bus.req_a = 4'b1100; bus.req_b = 4'b1010; bus.req_op = 3'b011; bus.req_valid = 1'b1;
    get_rsp(4'b0010, 4'b0011, 3'b010, 4'b0101, 3'b000, 1'b0, 10);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("pending accepted", {bus.alu_op, bus.req_ready}, {3'b011, 1'b0});
    get_rsp(4'b1100, 4'b1010, 3'b011, 4'b1000, 3'b010, 1'b0, 0);

    // Reset during ISSUE aborts the op and clears the sticky flag
    send(4'b0111, 4'b1001, 3'b010);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort state", {bus.alu_op, bus.rsp_valid, bus.req_ready, bus.chk_mismatch},
        {3'd0, 1'b0, 1'b1, 1'b0});
    for (int s = 0; s < 12; s++) begin
      @(posedge clk); #1;
      chk("no rsp after abort", {bus.rsp_valid, bus.alu_op}, 0);
    end

    // Randomized ops, faults and stalls against the arithmetic model
    exp_mis = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: rop = 3'b000; 1: rop = 3'b101; 2: rop = 3'b110; default: rop = 3'b111;
        endcase
      end else begin
        rop = 3'($urandom_range(1, 4));
      end
      fault = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      m = model(ra, rb, rop);
      if (m[7]) begin
        ec = m[6:3] ^ fault; ef = m[2:0]; ee = (fault != 4'd0);
        exp_mis = exp_mis | ee;
      end else begin
        ec = 4'd0; ef = 3'd0; ee = 1'b1;
      end
      send(ra, rb, rop);
      get_rsp(ra, rb, rop, ec, ef, ee, $urandom_range(0, 3));
      chk("random sticky", bus.chk_mismatch, exp_mis);
    end
    fault = 4'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/alu_serial_host.md
Name: alu_serial_host

Overview:
- Host-side controller for the team's bit-serial 4-bit ALU, which produces one result bit per clock while its opCode is held, with flags on the last bit.
- Accepts one operation request at a time over a valid/ready interface and drives the ALU's A/B/opCode inputs for exactly one full serial pass.
- Captures the ALU's C/Carry/Sign/Zero and returns them on a valid/ready response channel.
- Checks the captured result against an internal reference model and reports any mismatch.

Parameters:
- HOLD_CYCLES, 5, clocks the op code is held on alu_op. Must equal the ALU's per-op state count.
- SETTLE_CYCLES, 1, idle clocks (alu_op=000) between the end of hold and capture. Must be ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  4  operand A
- req_b  in  4  operand B
- req_op  in  3  001 XOR, 010 ADD, 011 AND, 100 SUB; all other codes illegal
- alu_a  out  4  ALU operand A
- alu_b  out  4  ALU operand B
- alu_op  out  3  ALU opCode; 000 = idle
- alu_c  in  4  ALU result
- alu_carry  in  1  ALU carry/borrow flag
- alu_sign  in  1  ALU sign flag
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_c  out  4  captured result
- rsp_flags  out  3  {carry, sign, zero}
- rsp_err  out  1  1 = illegal op or mismatch against the model
- chk_mismatch  out  1  sticky mismatch flag; cleared only by reset

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state IDLE; req_ready=1; rsp_valid=0.
  - alu_op=000; alu_a=0; alu_b=0.
  - rsp_c=0; rsp_flags=0; rsp_err=0; chk_mismatch=0.
  - Reset mid-operation aborts the operation and drops any pending response.
- Registered outputs only; no combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, SETTLE, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at edge E0:
    - Latch a, b, op and compute the expected model result.
    - Legal op: alu_a/alu_b/alu_op take the request values at E0; go to ISSUE.
    - Illegal op: go straight to RESP with rsp_err=1, rsp_c=0, rsp_flags=0. The ALU is not driven.
- ISSUE:
  - alu_op held at the request op for exactly HOLD_CYCLES clocks, E0 through E0+HOLD_CYCLES-1.
  - alu_a/alu_b are held stable for the same span.
  - At E0+HOLD_CYCLES: alu_op returns to 000; go to SETTLE.
- SETTLE:
  - Lasts SETTLE_CYCLES clocks with alu_op=000.
  - alu_a/alu_b keep their values.
- CAPTURE:
  - One clock. Sample alu_c and the three flags.
  - rsp_err = (captured != expected).
  - If rsp_err=1, set chk_mismatch.
- RESP:
  - rsp_valid=1; rsp_c/rsp_flags/rsp_err remain stable until rsp_ready=1.
  - Handshake completes on the edge where rsp_valid & rsp_ready = 1; go to IDLE.
  - A new request is accepted no earlier than the following edge, so there is at most one operation in flight.
- Latency (legal op, rsp_ready held 1):
  - rsp_valid rises at E0+HOLD_CYCLES+SETTLE_CYCLES+1 (E0+7 by default).
  - Back-to-back throughput is one operation per HOLD_CYCLES+SETTLE_CYCLES+3 clocks.
- req_ready=0 in every state other than IDLE; req_valid is ignored there.
- Reference model (4-bit operands, 5-bit intermediate):
  - ADD: C = (A+B)[3:0]; carry = (A+B)[4].
  - SUB: C = (A-B) mod 16; carry = borrow = (A<B).
  - AND, XOR: C = bitwise result; carry = 0.
  - All ops: zero = (C==0); sign = C[3].
- Edge cases:
  - rsp_ready held 0 keeps the block in RESP indefinitely, with ALU inputs idle (alu_op=000).
  - rsp_ready=1 while rsp_valid=0 has no effect.
  - Requests with the same op back-to-back are allowed; every pass uses exactly HOLD_CYCLES so the ALU's per-op phase counter returns to its start state.

Test Plan:
- Reset, then request ADD A=0111 B=1001 → alu_op=010 for 5 clocks; rsp_valid at E0+7; rsp_c=0000, flags {1,0,1}, rsp_err=0.
- Request SUB A=0011 B=0101 → rsp_c=1110, flags {1,1,0}, rsp_err=0. Follow immediately with AND A=1100 B=1010 → rsp_c=1000, flags {0,1,0}.
- Request op=110 with A=1111 B=0001 → alu_op stays 000; rsp_valid at E0+1; rsp_err=1; chk_mismatch stays 0.
- ALU stub forcing alu_c=0001 on an XOR A=0101 B=0101 request (expected 0000) → rsp_err=1; chk_mismatch=1 and stays set across later clean operations until reset.
- rsp_ready held 0 for 10 clocks after rsp_valid, while req_valid=1 → req_ready=0 and rsp_* stable throughout; release rsp_ready → handshake, then the pending request is accepted on the next edge.
- Assert rst_n=0 for 1 clock during the ISSUE of an ADD → next cycle IDLE, alu_op=000, rsp_valid=0, req_ready=1, no response emitted.
